tic_tac_toe_turn_sequencer: RTL and testbench

Turn sequencer and arbiter for the tic-tac-toe board datapath: the 9 two-bit position registers, the winner detector and the no-space detector.
- Owns the board's move-write port and shares it between two move requesters (player, computer) through valid/ready handshakes.
- Validates each move against the current board, sequences write, then win/draw check, then turn hand-over.
- Keeps per-session score counters.

---
 rtl/tic_tac_toe_turn_sequencer_pkg.sv | 43 ++++
 rtl/tic_tac_toe_turn_sequencer_if.sv | 43 ++++
 rtl/tic_tac_toe_turn_sequencer_sat_counter.sv | 24 ++
 rtl/tic_tac_toe_turn_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_tic_tac_toe_turn_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tic_tac_toe_turn_sequencer_pkg.sv
// Shared codes, state encoding and board helpers for the tic-tac-toe turn sequencer.
package tic_tac_toe_pkg;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    localparam logic [1:0] RESULT_NONE     = 2'b00;
    localparam logic [1:0] RESULT_PLAYER   = 2'b01;
    localparam logic [1:0] RESULT_COMPUTER = 2'b10;
    localparam logic [1:0] RESULT_DRAW     = 2'b11;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned POS_W     = 4;
    localparam int unsigned BOARD_W   = 2 * NUM_CELLS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_PL = 3'd1,
        WAIT_PC = 3'd2,
        WRITE   = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } ttt_state_t;

    // An out-of-range index never matches a cell, so it is reported as not free.
    function automatic logic cell_is_free(input logic [BOARD_W-1:0] board,
                                          input logic [POS_W-1:0]   pos);
        logic free;
        free = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (pos == POS_W'(i)) begin
                free = (board[2*i +: 2] == CELL_EMPTY);
            end
        end
        return free;
    endfunction

    function automatic logic [1:0] other_mover(input logic [1:0] mover);
        return (mover == CELL_PLAYER) ? CELL_COMPUTER : CELL_PLAYER;
    endfunction

endpackage

// File: rtl/tic_tac_toe_turn_sequencer_if.sv
// Move-request, board-status and result bundle between the sequencer and its environment.
interface tic_tac_toe_turn_sequencer_if #(
    parameter int unsigned SCORE_W = 8
);
    import tic_tac_toe_pkg::*;

    logic                 start;
    logic                 pl_valid;
    logic [POS_W-1:0]     pl_pos;
    logic                 pl_ready;
    logic                 pc_valid;
    logic [POS_W-1:0]     pc_pos;
    logic                 pc_ready;
    logic [BOARD_W-1:0]   board;
    logic                 win;
    logic [1:0]           who;
    logic                 no_space;
    logic                 board_clr;
    logic                 wr_en;
    logic [POS_W-1:0]     wr_pos;
    logic [1:0]           wr_who;
    logic [1:0]           turn;
    logic                 illegal;
    logic                 timeout;
    logic                 game_over;
    logic [1:0]           result;
    logic [SCORE_W-1:0]   pl_score;
    logic [SCORE_W-1:0]   pc_score;
    logic [SCORE_W-1:0]   draw_count;

    modport slave (
        input  start, pl_valid, pl_pos, pc_valid, pc_pos, board, win, who, no_space,
        output pl_ready, pc_ready, board_clr, wr_en, wr_pos, wr_who, turn, illegal,
               timeout, game_over, result, pl_score, pc_score, draw_count
    );

    modport master (
        output start, pl_valid, pl_pos, pc_valid, pc_pos, board, win, who, no_space,
        input  pl_ready, pc_ready, board_clr, wr_en, wr_pos, wr_who, turn, illegal,
               timeout, game_over, result, pl_score, pc_score, draw_count
    );

endinterface

// File: rtl/tic_tac_toe_turn_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; used for the session tallies.
module ttt_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clock,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on request, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clock) begin
        if (!i_clr_n) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tic_tac_toe_turn_sequencer.sv
// Turn sequencer/arbiter owning the board write port. Optional per-turn forfeit
// timer is built when TTT_MOVE_TIMEOUT_EN is defined.
module tic_tac_toe_turn_sequencer
    import tic_tac_toe_pkg::*;
#(
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned TURN_TIMEOUT = 64
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    tic_tac_toe_turn_sequencer_if.slave  io_ttt
);

    if ((TURN_TIMEOUT < 32'd2) || (TURN_TIMEOUT > 32'd65535)) begin : g_bad_timeout
        $error("TURN_TIMEOUT must lie in 2..65535");
    end

    ttt_state_t         r_state;
    logic [1:0]         r_turn;
    logic               r_board_clr;
    logic               r_wr_en;
    logic [POS_W-1:0]   r_wr_pos;
    logic [1:0]         r_wr_who;
    logic               r_illegal;
    logic               r_game_over;
    logic [1:0]         r_result;

    logic               w_acc;
    logic [POS_W-1:0]   w_mv_pos;
    logic [BOARD_W-1:0] w_board_view;
    logic               w_legal;
    logic               w_inc_pl;
    logic               w_inc_pc;
    logic               w_inc_draw;
    logic [SCORE_W-1:0] w_pl_score;
    logic [SCORE_W-1:0] w_pc_score;
    logic [SCORE_W-1:0] w_draw_count;

`ifdef TTT_MOVE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TURN_TIMEOUT - 32'd1);
    logic [15:0] r_to_cnt;
    logic        r_timeout;
`endif

    assign io_ttt.pl_ready = (r_state == WAIT_PL);
    assign io_ttt.pc_ready = (r_state == WAIT_PC);

    assign w_acc    = ((r_state == WAIT_PL) && io_ttt.pl_valid) ||
                      ((r_state == WAIT_PC) && io_ttt.pc_valid);
    assign w_mv_pos = (r_state == WAIT_PL) ? io_ttt.pl_pos : io_ttt.pc_pos;

    // While board_clr is pulsing the position registers still show the old game;
    // they are cleared at this same edge, so validate against an empty board.
    assign w_board_view = r_board_clr ? {BOARD_W{1'b0}} : io_ttt.board;
    assign w_legal      = cell_is_free(w_board_view, w_mv_pos);

    assign w_inc_pl   = (r_state == CHECK) && io_ttt.win && (io_ttt.who == CELL_PLAYER);
    assign w_inc_pc   = (r_state == CHECK) && io_ttt.win && (io_ttt.who == CELL_COMPUTER);
    assign w_inc_draw = (r_state == CHECK) && !io_ttt.win && io_ttt.no_space;

    // Game FSM: arbitration, move validation, write/check sequencing and hand-over.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_turn      <= CELL_EMPTY;
            r_board_clr <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_pos    <= {POS_W{1'b0}};
            r_wr_who    <= CELL_EMPTY;
            r_illegal   <= 1'b0;
            r_game_over <= 1'b0;
            r_result    <= RESULT_NONE;
`ifdef TTT_MOVE_TIMEOUT_EN
            r_to_cnt    <= 16'd0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_board_clr <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_pos    <= {POS_W{1'b0}};
            r_wr_who    <= CELL_EMPTY;
            r_illegal   <= 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (io_ttt.start) begin
                        r_board_clr <= 1'b1;
                        r_result    <= RESULT_NONE;
                        r_turn      <= CELL_PLAYER;
                        r_game_over <= 1'b0;
                        r_state     <= WAIT_PL;
`ifdef TTT_MOVE_TIMEOUT_EN
                        r_to_cnt    <= 16'd0;
`endif
                    end
                end
                WAIT_PL, WAIT_PC: begin
                    if (w_acc) begin
                        if (w_legal) begin
                            r_wr_en  <= 1'b1;
                            r_wr_pos <= w_mv_pos;
                            r_wr_who <= r_turn;
                            r_state  <= WRITE;
`ifdef TTT_MOVE_TIMEOUT_EN
                            r_to_cnt <= 16'd0;
`endif
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
`ifdef TTT_MOVE_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_to_cnt  <= 16'd0;
                        r_turn    <= other_mover(r_turn);
                        r_state   <= (r_state == WAIT_PL) ? WAIT_PC : WAIT_PL;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                WRITE: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (io_ttt.win) begin
                        case (io_ttt.who)
                            CELL_PLAYER:   r_result <= RESULT_PLAYER;
                            CELL_COMPUTER: r_result <= RESULT_COMPUTER;
                            default:       r_result <= io_ttt.who;
                        endcase
                        r_turn      <= CELL_EMPTY;
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else if (io_ttt.no_space) begin
                        r_result    <= RESULT_DRAW;
                        r_turn      <= CELL_EMPTY;
                        r_game_over <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_turn  <= other_mover(r_turn);
                        r_state <= (r_turn == CELL_PLAYER) ? WAIT_PC : WAIT_PL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ttt_sat_counter #(.W(SCORE_W)) u_pl_score (
        .i_clock (i_clock),
        .i_clr_n (i_reset),
        .i_inc   (w_inc_pl),
        .o_count (w_pl_score)
    );

    ttt_sat_counter #(.W(SCORE_W)) u_pc_score (
        .i_clock (i_clock),
        .i_clr_n (i_reset),
        .i_inc   (w_inc_pc),
        .o_count (w_pc_score)
    );

    ttt_sat_counter #(.W(SCORE_W)) u_draw_count (
        .i_clock (i_clock),
        .i_clr_n (i_reset),
        .i_inc   (w_inc_draw),
        .o_count (w_draw_count)
    );

    assign io_ttt.board_clr  = r_board_clr;
    assign io_ttt.wr_en      = r_wr_en;
    assign io_ttt.wr_pos     = r_wr_pos;
    assign io_ttt.wr_who     = r_wr_who;
    assign io_ttt.turn       = r_turn;
    assign io_ttt.illegal    = r_illegal;
    assign io_ttt.game_over  = r_game_over;
    assign io_ttt.result     = r_result;
    assign io_ttt.pl_score   = w_pl_score;
    assign io_ttt.pc_score   = w_pc_score;
    assign io_ttt.draw_count = w_draw_count;
`ifdef TTT_MOVE_TIMEOUT_EN
    assign io_ttt.timeout    = r_timeout;
`else
    assign io_ttt.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_tic_tac_toe_turn_sequencer.sv
// Directed bench for the turn sequencer, with a behavioural board/winner/no-space model
// standing in for the position registers. Timeout scenarios run when TTT_MOVE_TIMEOUT_EN is set.
module tb_tic_tac_toe_turn_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tic_tac_toe_turn_sequencer_if #(.SCORE_W(8)) bus ();

    tic_tac_toe_turn_sequencer #(.SCORE_W(8), .TURN_TIMEOUT(8)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_ttt  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic overlap_seen = 1'b0;

`ifdef TTT_MOVE_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 10;
`endif

    // Position registers: cleared by board_clr, written by wr_en.
    logic [17:0] env_board = 18'd0;
    always @(posedge clk) begin
        if (bus.board_clr) env_board <= 18'd0;
        else if (bus.wr_en)
            for (int i = 0; i < 9; i++) if (bus.wr_pos == 4'(i)) env_board[2*i +: 2] <= bus.wr_who;
        if (bus.board_clr && bus.wr_en) overlap_seen <= 1'b1;
    end

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [1:0] winner(input logic [17:0] b);
        logic [1:0] w;
        w = 2'b00;
        for (int l = 0; l < 8; l++) begin
            if (b[2*lines[l][0] +: 2] != 2'b00 &&
                b[2*lines[l][0] +: 2] == b[2*lines[l][1] +: 2] &&
                b[2*lines[l][0] +: 2] == b[2*lines[l][2] +: 2]) w = b[2*lines[l][0] +: 2];
        end
        return w;
    endfunction

    function automatic logic full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'b00) f = 1'b0;
        return f;
    endfunction

    assign bus.board    = env_board;
    assign bus.who      = winner(env_board);
    assign bus.win      = (winner(env_board) != 2'b00);
    assign bus.no_space = full(env_board);

    logic [3:0] mv_pl_win [9] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] mv_draw   [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic play(input logic is_pl, input logic [3:0] pos);
        int k;
        k = 0;
        while (((is_pl ? bus.pl_ready : bus.pc_ready) !== 1'b1) && k < 50) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= 50) $display("FAIL ready_wait: mover %0d never got ready (actual 0, required 1)", is_pl);
        else n_pass++;
        if (is_pl) begin bus.pl_valid = 1'b1; bus.pl_pos = pos; end
        else       begin bus.pc_valid = 1'b1; bus.pc_pos = pos; end
        step();
        bus.pl_valid = 1'b0;
        bus.pc_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (bus.game_over !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.game_over !== 1'b1) $display("FAIL game_over_wait: game_over=%b required 1", bus.game_over);
        else n_pass++;
    endtask

    task automatic play_game(input logic [3:0] mv [9], input int n);
        do_start();
        for (int i = 0; i < n; i++) play((i % 2) == 0, mv[i]);
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b1; bus.pl_valid = 1'b1; bus.pl_pos = 4'd0;
        bus.pc_valid = 1'b0; bus.pc_pos = 4'd0;
        repeat (3) step();
        n_checks++;
        if ({bus.pl_ready, bus.pc_ready, bus.board_clr, bus.wr_en, bus.wr_pos, bus.wr_who, bus.turn,
             bus.illegal, bus.timeout, bus.game_over, bus.result, bus.pl_score, bus.pc_score,
             bus.draw_count} !== 44'd0)
            $display("FAIL reset_outputs: turn=%b result=%b ready=%b%b wr_en=%b clr=%b (all required 0)",
                     bus.turn, bus.result, bus.pl_ready, bus.pc_ready, bus.wr_en, bus.board_clr);
        else n_pass++;
        rst_n = 1'b1; bus.start = 1'b0; bus.pl_valid = 1'b0;
        step();
        n_checks++;
        if (bus.pl_ready !== 1'b0) $display("FAIL idle_no_ready: pl_ready=%b required 0", bus.pl_ready);
        else n_pass++;
    endtask

    task automatic test_start();
        logic bad;
        do_start();
        n_checks++;
        if ({bus.board_clr, bus.turn, bus.pl_ready, bus.pc_ready} !== 5'b1_01_10)
            $display("FAIL start: clr=%b turn=%b pl_ready=%b pc_ready=%b required 1 01 1 0",
                     bus.board_clr, bus.turn, bus.pl_ready, bus.pc_ready);
        else n_pass++;
        bad = 1'b0;
        bus.pc_valid = 1'b1; bus.pc_pos = 4'd2;
        for (int i = 0; i < HOLD; i++) begin
            step();
            if (bus.wr_en || bus.illegal || bus.pc_ready || bus.board_clr) bad = 1'b1;
        end
        bus.pc_valid = 1'b0;
        n_checks++;
        if (bad !== 1'b0 || bus.turn !== 2'b01)
            $display("FAIL pc_ignored: activity=%b turn=%b required 0 01", bad, bus.turn);
        else n_pass++;
    endtask

    task automatic test_latency();
        bus.pl_valid = 1'b1; bus.pl_pos = 4'd4;
        step();
        bus.pl_valid = 1'b0;
        n_checks++;
        if ({bus.wr_en, bus.wr_pos, bus.wr_who} !== 7'b1_0100_01)
            $display("FAIL write_strobe: wr_en=%b wr_pos=%0d wr_who=%b required 1 4 01",
                     bus.wr_en, bus.wr_pos, bus.wr_who);
        else n_pass++;
        step();
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.pc_ready !== 1'b0)
            $display("FAIL check_cycle: wr_en=%b pc_ready=%b required 0 0", bus.wr_en, bus.pc_ready);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.pc_ready, bus.pl_ready, bus.turn, bus.board[9:8]} !== 6'b1_0_10_01)
            $display("FAIL handover: pc_ready=%b pl_ready=%b turn=%b cell4=%b required 1 0 10 01",
                     bus.pc_ready, bus.pl_ready, bus.turn, bus.board[9:8]);
        else n_pass++;
    endtask

    task automatic test_illegal();
        bus.pc_valid = 1'b1; bus.pc_pos = 4'd4;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if ({bus.illegal, bus.wr_en, bus.pc_ready} !== 3'b101)
            $display("FAIL illegal_occupied: illegal=%b wr_en=%b pc_ready=%b required 1 0 1",
                     bus.illegal, bus.wr_en, bus.pc_ready);
        else n_pass++;
        step();
        n_checks++;
        if (bus.illegal !== 1'b0) $display("FAIL illegal_pulse_len: illegal=%b required 0", bus.illegal);
        else n_pass++;
        bus.pc_valid = 1'b1; bus.pc_pos = 4'd9;
        step();
        n_checks++;
        if ({bus.illegal, bus.wr_en, bus.pc_ready} !== 3'b101)
            $display("FAIL illegal_range: illegal=%b wr_en=%b pc_ready=%b required 1 0 1",
                     bus.illegal, bus.wr_en, bus.pc_ready);
        else n_pass++;
        bus.pc_pos = 4'd0;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if ({bus.illegal, bus.wr_en, bus.wr_pos, bus.wr_who} !== 8'b0_1_0000_10)
            $display("FAIL retry_write: illegal=%b wr_en=%b wr_pos=%0d wr_who=%b required 0 1 0 10",
                     bus.illegal, bus.wr_en, bus.wr_pos, bus.wr_who);
        else n_pass++;
    endtask

    task automatic test_midgame_start();
        step(); step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.board_clr, bus.turn, bus.pl_ready, bus.board[1:0]} !== 6'b0_01_1_10)
            $display("FAIL start_ignored: clr=%b turn=%b pl_ready=%b cell0=%b required 0 01 1 10",
                     bus.board_clr, bus.turn, bus.pl_ready, bus.board[1:0]);
        else n_pass++;
    endtask

    task automatic test_pc_win();
        play(1'b1, 4'd8); play(1'b0, 4'd3); play(1'b1, 4'd5); play(1'b0, 4'd6);
        wait_done();
        n_checks++;
        if ({bus.result, bus.turn, bus.pc_score, bus.pl_score} !== {2'b10, 2'b00, 8'd1, 8'd0})
            $display("FAIL pc_win: result=%b turn=%b pc_score=%0d pl_score=%0d required 10 00 1 0",
                     bus.result, bus.turn, bus.pc_score, bus.pl_score);
        else n_pass++;
    endtask

    task automatic test_pl_win();
        do_start();
        n_checks++;
        if ({bus.board_clr, bus.result, bus.game_over, bus.pc_score} !== {1'b1, 2'b00, 1'b0, 8'd1})
            $display("FAIL restart: clr=%b result=%b game_over=%b pc_score=%0d required 1 00 0 1",
                     bus.board_clr, bus.result, bus.game_over, bus.pc_score);
        else n_pass++;
        for (int i = 0; i < 5; i++) play((i % 2) == 0, mv_pl_win[i]);
        wait_done();
        n_checks++;
        if ({bus.result, bus.pl_score, bus.pc_score, bus.draw_count} !== {2'b01, 8'd1, 8'd1, 8'd0})
            $display("FAIL pl_win: result=%b pl=%0d pc=%0d draws=%0d required 01 1 1 0",
                     bus.result, bus.pl_score, bus.pc_score, bus.draw_count);
        else n_pass++;
    endtask

    task automatic test_draw();
        play_game(mv_draw, 9);
        n_checks++;
        if ({bus.result, bus.draw_count, bus.pl_score} !== {2'b11, 8'd1, 8'd1})
            $display("FAIL draw: result=%b draws=%0d pl=%0d required 11 1 1",
                     bus.result, bus.draw_count, bus.pl_score);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 254; g++) play_game(mv_draw, 9);
        n_checks++;
        if (bus.draw_count !== 8'd255) $display("FAIL draw_255: draws=%0d required 255", bus.draw_count);
        else n_pass++;
        play_game(mv_draw, 9);
        n_checks++;
        if ({bus.draw_count, bus.pl_score, bus.pc_score} !== {8'd255, 8'd1, 8'd1})
            $display("FAIL draw_saturate: draws=%0d pl=%0d pc=%0d required 255 1 1",
                     bus.draw_count, bus.pl_score, bus.pc_score);
        else n_pass++;
    endtask

`ifndef TTT_MOVE_TIMEOUT_EN
    task automatic test_hold_forever();
        logic seen;
        seen = 1'b0;
        do_start();
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.timeout) seen = 1'b1;
        end
        n_checks++;
        if ({seen, bus.turn, bus.pl_ready} !== 4'b0_01_1)
            $display("FAIL no_timeout: timeout_seen=%b turn=%b pl_ready=%b required 0 01 1",
                     seen, bus.turn, bus.pl_ready);
        else n_pass++;
    endtask
`else
    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        do_start();
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.timeout) seen = 1'b1;
        end
        step();
        n_checks++;
        if ({seen, bus.timeout, bus.turn, bus.wr_en, bus.pc_ready} !== 6'b0_1_10_0_1)
            $display("FAIL timeout_fire: early=%b timeout=%b turn=%b wr_en=%b pc_ready=%b required 0 1 10 0 1",
                     seen, bus.timeout, bus.turn, bus.wr_en, bus.pc_ready);
        else n_pass++;
        repeat (7) step();
        bus.pc_valid = 1'b1; bus.pc_pos = 4'd0;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if ({bus.timeout, bus.wr_en, bus.wr_who} !== 4'b0_1_10)
            $display("FAIL accept_beats_timeout: timeout=%b wr_en=%b wr_who=%b required 0 1 10",
                     bus.timeout, bus.wr_en, bus.wr_who);
        else n_pass++;
        step(); step();
    endtask
`endif

    task automatic test_mid_reset();
        bus.pl_valid = 1'b1; bus.pl_pos = 4'd1;
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({bus.wr_en, bus.turn, bus.pl_ready, bus.timeout, bus.result, bus.pl_score, bus.draw_count}
            !== 23'd0)
            $display("FAIL mid_reset: wr_en=%b turn=%b pl_ready=%b result=%b pl=%0d draws=%0d required all 0",
                     bus.wr_en, bus.turn, bus.pl_ready, bus.result, bus.pl_score, bus.draw_count);
        else n_pass++;
        rst_n = 1'b1;
        bus.pl_valid = 1'b0;
        step();
        n_checks++;
        if ({bus.wr_en, bus.pl_ready, bus.game_over} !== 3'b000)
            $display("FAIL move_abandoned: wr_en=%b pl_ready=%b game_over=%b required 0 0 0",
                     bus.wr_en, bus.pl_ready, bus.game_over);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_latency();
        test_illegal();
        test_midgame_start();
        test_pc_win();
        test_pl_win();
        test_draw();
        test_saturation();
`ifndef TTT_MOVE_TIMEOUT_EN
        test_hold_forever();
`else
        test_timeout();
`endif
        test_mid_reset();
        n_checks++;
        if (overlap_seen !== 1'b0) $display("FAIL clr_wr_exclusive: overlap=%b required 0", overlap_seen);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
